incdec_seq_ctrl: RTL and testbench

Sequential controller that applies one increment or decrement to a wide operand of `words` × `width` bits. It time-shares a single `IncDecC` slice of `width` bits across all slices, least significant slice first, and carries between slices through a register. It stops early once the carry dies. Requests are accepted on a valid/ready input handshake and results are returned on a valid/ready output handshake. The block lets wide counters and pointer arithmetic reuse one narrow prefix incrementer instead of a full-width one.

---
 rtl/incdec_seq_ctrl_if.sv | 34 +++
 rtl/incdec_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_incdec_seq_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/incdec_seq_ctrl_if.sv
// rtl/incdec_seq_ctrl_if.sv - request/result handshake bundle for the sequential inc/dec controller
interface incdec_seq_ctrl_if #(
  parameter int width = 8,
  parameter int words = 4
);
  localparam int W  = width * words;
  localparam int SW = $clog2(words + 1);

  // Request side
  logic          valid_i;
  logic          ready_o;
  logic [W-1:0]  a_i;
  logic          ci_i;
  logic          dec_i;

  // Result side
  logic          valid_o;
  logic          ready_i;
  logic [W-1:0]  z_o;
  logic          co_o;
  logic [SW-1:0] slices_o;

  // Controller side
  modport slave (
    input  valid_i, a_i, ci_i, dec_i, ready_i,
    output ready_o, valid_o, z_o, co_o, slices_o
  );

  // Requester / result consumer side
  modport master (
    output valid_i, a_i, ci_i, dec_i, ready_i,
    input  ready_o, valid_o, z_o, co_o, slices_o
  );
endinterface

// File: rtl/incdec_seq_ctrl.sv
// rtl/incdec_seq_ctrl.sv - wide increment/decrement built from one time-shared narrow slice
package lau_pkg;
  typedef enum logic {SLOW, FAST} speed_e;
endpackage

// Narrow incrementer/decrementer: {co, z} = dec ? a - ci : a + ci.
// A bit flips when every lower bit "propagates": 1s for increment, 0s for
// decrement, so both modes share one AND-prefix over a ^ {dec}.
module IncDecC #(
  parameter int              width = 8,
  parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
  input  logic [width-1:0] a_i,
  input  logic             ci_i,
  input  logic             dec_i,
  output logic [width-1:0] z_o,
  output logic             co_o
);
  localparam int L = (width > 1) ? $clog2(width) : 1;

  logic [width-1:0] w_t;
  logic [width:0]   w_p;

  assign w_t = a_i ^ {width{dec_i}};

  if (speed == lau_pkg::FAST) begin : g_fast
    logic [L:0][width-1:0] w_lvl;

    // Log-depth inclusive prefix AND of the propagate bits
    always_comb begin
      w_lvl    = '0;
      w_lvl[0] = w_t;
      for (int l = 0; l < L; l++) begin
        for (int i = 0; i < width; i++) begin
          if (i >= (1 << l)) begin
            w_lvl[l+1][i] = w_lvl[l][i] & w_lvl[l][i - (1 << l)];
          end else begin
            w_lvl[l+1][i] = w_lvl[l][i];
          end
        end
      end
      w_p    = '0;
      w_p[0] = ci_i;
      for (int i = 0; i < width; i++) begin
        w_p[i+1] = ci_i & w_lvl[L][i];
      end
    end
  end else begin : g_slow
    // Linear ripple of the carry/borrow through the propagate bits
    always_comb begin
      w_p    = '0;
      w_p[0] = ci_i;
      for (int i = 0; i < width; i++) begin
        w_p[i+1] = w_p[i] & w_t[i];
      end
    end
  end

  assign z_o  = a_i ^ w_p[width-1:0];
  assign co_o = w_p[width];
endmodule

// Controller: walks the operand slice by slice from the LSB, stopping as soon
// as the carry/borrow dies so short carries finish in one cycle.
module incdec_seq_ctrl #(
  parameter int              width = 8,
  parameter int              words = 4,
  parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  incdec_seq_ctrl_if.slave bus
);
  localparam int W  = width * words;
  localparam int IW = (words > 1) ? $clog2(words) : 1;
  localparam int SW = $clog2(words + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e         r_state;
  state_e         w_next;
  logic [W-1:0]   r_z;
  logic           r_carry;
  logic           r_dec;
  logic           r_co;
  logic [IW-1:0]  r_idx;
  logic [SW-1:0]  r_slices;

  logic [width-1:0] w_slice_a;
  logic [width-1:0] w_slice_z;
  logic             w_slice_co;
  logic             w_last;
  logic             w_accept;

  assign w_slice_a = r_z[r_idx*width +: width];
  assign w_last    = (r_idx == IW'(words - 1));
  assign w_accept  = bus.valid_i && (r_state == S_IDLE);

  IncDecC #(
    .width (width),
    .speed (speed)
  ) u_slice (
    .a_i   (w_slice_a),
    .ci_i  (r_carry),
    .dec_i (r_dec),
    .z_o   (w_slice_z),
    .co_o  (w_slice_co)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: a zero carry-in skips RUN; RUN ends on a dead carry or the top slice
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.valid_i) begin
          w_next = bus.ci_i ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (!w_slice_co || w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.ready_i) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: latch on accept, write one slice back per RUN cycle, hold in DONE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_z      <= '0;
      r_carry  <= 1'b0;
      r_dec    <= 1'b0;
      r_co     <= 1'b0;
      r_idx    <= '0;
      r_slices <= '0;
    end else if (w_accept) begin
      r_z      <= bus.a_i;
      r_carry  <= bus.ci_i;
      r_dec    <= bus.dec_i;
      r_co     <= 1'b0;
      r_idx    <= '0;
      r_slices <= '0;
    end else if (r_state == S_RUN) begin
      r_z[r_idx*width +: width] <= w_slice_z;
      r_carry                   <= w_slice_co;
      r_slices                  <= r_slices + SW'(1);
      if (!w_slice_co) begin
        r_co <= 1'b0;
      end else if (w_last) begin
        r_co <= 1'b1;
      end else begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  assign bus.ready_o  = (r_state == S_IDLE);
  assign bus.valid_o  = (r_state == S_DONE);
  assign bus.z_o      = r_z;
  assign bus.co_o     = r_co;
  assign bus.slices_o = r_slices;
endmodule

// File: tb/tb_incdec_seq_ctrl.sv
// tb/tb_incdec_seq_ctrl.sv - scoreboard bench for the sequential inc/dec controller
module tb_incdec_seq_ctrl;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  typedef struct {
    logic [31:0] z;
    logic        co;
    logic [2:0]  sl;
    int          lat;
  } exp_t;

  exp_t sb[$];

  incdec_seq_ctrl_if #(.width(8), .words(4)) bus ();

  incdec_seq_ctrl #(.width(8), .words(4), .speed(lau_pkg::FAST)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 33-bit arithmetic; k counts slices up to the first one that absorbs the carry
  function automatic exp_t model(input logic [31:0] a, input logic ci, input logic dec);
    exp_t        e;
    logic [32:0] r;
    logic [7:0]  s;
    int          k;
    r    = dec ? ({1'b0, a} - 33'(ci)) : ({1'b0, a} + 33'(ci));
    e.z  = r[31:0];
    e.co = r[32];
    k    = 0;
    if (ci) begin
      k = 4;
      for (int i = 3; i >= 0; i--) begin
        s = a[i*8 +: 8];
        if (dec ? (s != 8'h00) : (s != 8'hFF)) k = i + 1;
      end
    end
    e.sl  = 3'(k);
    e.lat = k;
    return e;
  endfunction

  // Offer one request, scramble inputs after acceptance, wait for valid_o
  task automatic run_op(input logic [31:0] a, input logic ci, input logic dec,
                        output logic [31:0] z, output logic co, output logic [2:0] sl,
                        output int lat, output bit tmo);
    int n;
    tmo = 1'b0;
    @(negedge clk);
    bus.a_i = a; bus.ci_i = ci; bus.dec_i = dec; bus.valid_i = 1'b1;
    n = 0;
    while (!bus.ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) tmo = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    bus.a_i     = $urandom;
    bus.ci_i    = ~ci;
    bus.dec_i   = ~dec;
    lat = 0;
    while (!bus.valid_o && !tmo) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat > 20) tmo = 1'b1;
    end
    z  = bus.z_o;
    co = bus.co_o;
    sl = bus.slices_o;
  endtask

  task automatic ack();
    @(negedge clk);
    bus.ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.ready_i = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", bus.ready_o); end
    n_cmp++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", bus.valid_o); end
    n_cmp++; if (bus.z_o !== 32'h0) begin n_err++; $display("FAIL reset_z got=%h exp=0", bus.z_o); end
    n_cmp++; if (bus.co_o !== 1'b0) begin n_err++; $display("FAIL reset_co got=%b exp=0", bus.co_o); end
    n_cmp++; if (bus.slices_o !== 3'd0) begin n_err++; $display("FAIL reset_slices got=%0d exp=0", bus.slices_o); end
  endtask

  // Directed vectors from a table: {a, ci, dec}
  task automatic test_arith(input string name, input logic [31:0] av[], input logic ci, input logic dec);
    logic [31:0] z; logic co; logic [2:0] sl; int lat; bit tmo; exp_t e;
    foreach (av[i]) begin
      sb.push_back(model(av[i], ci, dec));
      run_op(av[i], ci, dec, z, co, sl, lat, tmo);
      ack();
      e = sb.pop_front();
      n_cmp++; if (tmo) begin n_err++; $display("FAIL %s_timeout a=%h", name, av[i]); end
      n_cmp++; if (z !== e.z) begin n_err++; $display("FAIL %s_z a=%h got=%h exp=%h", name, av[i], z, e.z); end
      n_cmp++; if (co !== e.co) begin n_err++; $display("FAIL %s_co a=%h got=%b exp=%b", name, av[i], co, e.co); end
      n_cmp++; if (sl !== e.sl) begin n_err++; $display("FAIL %s_slices a=%h got=%0d exp=%0d", name, av[i], sl, e.sl); end
      n_cmp++; if (lat != e.lat) begin n_err++; $display("FAIL %s_latency a=%h got=%0d exp=%0d", name, av[i], lat, e.lat); end
    end
  endtask

  task automatic test_inc();
    logic [31:0] av[] = '{32'h12345600, 32'h00FFFFFF, 32'hFFFFFFFF, 32'h0000FFFE};
    test_arith("inc", av, 1'b1, 1'b0);
  endtask

  task automatic test_dec();
    logic [31:0] av[] = '{32'h00010000, 32'h00000000, 32'h80000000, 32'h00000001};
    test_arith("dec", av, 1'b1, 1'b1);
  endtask

  task automatic test_passthru();
    logic [31:0] av[] = '{32'hDEADBEEF, 32'h00000000};
    test_arith("pass_dec", av, 1'b0, 1'b1);
    test_arith("pass_inc", av, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [31:0] z; logic co; logic [2:0] sl; int lat; bit tmo; exp_t e;
    sb.push_back(model(32'h0000FFFF, 1'b1, 1'b0));
    run_op(32'h0000FFFF, 1'b1, 1'b0, z, co, sl, lat, tmo);
    e = sb.pop_front();
    n_cmp++; if (tmo || z !== e.z || co !== e.co || sl !== e.sl) begin
      n_err++; $display("FAIL bp_result got=%h/%b/%0d exp=%h/%b/%0d", z, co, sl, e.z, e.co, e.sl);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.valid_i = ~bus.valid_i;
      bus.a_i     = $urandom;
      bus.ci_i    = ~bus.ci_i;
      @(posedge clk);
      #1;
      n_cmp++; if (bus.valid_o !== 1'b1) begin n_err++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", c, bus.valid_o); end
      n_cmp++; if (bus.ready_o !== 1'b0) begin n_err++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", c, bus.ready_o); end
      n_cmp++; if (bus.z_o !== e.z || bus.co_o !== e.co || bus.slices_o !== e.sl) begin
        n_err++; $display("FAIL bp_hold cyc=%0d got=%h/%b/%0d exp=%h/%b/%0d", c, bus.z_o, bus.co_o, bus.slices_o, e.z, e.co, e.sl);
      end
    end
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.ready_i = 1'b0;
    n_cmp++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got=%b exp=1", bus.ready_o); end
    n_cmp++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL bp_release_valid got=%b exp=0", bus.valid_o); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] z; logic co; logic [2:0] sl; int lat; bit tmo; exp_t e;
    @(negedge clk);
    bus.a_i = 32'hFFFFFFFF; bus.ci_i = 1'b1; bus.dec_i = 1'b0; bus.valid_i = 1'b1;
    @(posedge clk);
    #1 bus.valid_i = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
      n_err++; $display("FAIL midrst_hs got=%b/%b exp=1/0", bus.ready_o, bus.valid_o);
    end
    n_cmp++; if (bus.z_o !== 32'h0 || bus.co_o !== 1'b0 || bus.slices_o !== 3'd0) begin
      n_err++; $display("FAIL midrst_out got=%h/%b/%0d exp=0/0/0", bus.z_o, bus.co_o, bus.slices_o);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(model(32'h000000FF, 1'b1, 1'b0));
    run_op(32'h000000FF, 1'b1, 1'b0, z, co, sl, lat, tmo);
    ack();
    e = sb.pop_front();
    n_cmp++; if (tmo || z !== e.z || co !== e.co || sl !== e.sl || lat != e.lat) begin
      n_err++; $display("FAIL midrst_next got=%h/%b/%0d/%0d exp=%h/%b/%0d/%0d", z, co, sl, lat, e.z, e.co, e.sl, e.lat);
    end
  endtask

  // Random operands biased toward 00/FF bytes so every carry length appears
  task automatic test_back_to_back();
    logic [31:0] a, z; logic co, ci, dec; logic [2:0] sl; int lat; bit tmo; exp_t e;
    for (int t = 0; t < 24; t++) begin
      for (int b = 0; b < 4; b++) begin
        case ($urandom_range(0, 2))
          0:       a[b*8 +: 8] = 8'h00;
          1:       a[b*8 +: 8] = 8'hFF;
          default: a[b*8 +: 8] = 8'($urandom);
        endcase
      end
      ci  = ($urandom_range(0, 5) != 0);
      dec = 1'($urandom);
      sb.push_back(model(a, ci, dec));
      run_op(a, ci, dec, z, co, sl, lat, tmo);
      ack();
      e = sb.pop_front();
      n_cmp++; if (tmo || z !== e.z || co !== e.co || sl !== e.sl || lat != e.lat) begin
        n_err++; $display("FAIL b2b a=%h ci=%b dec=%b got=%h/%b/%0d/%0d exp=%h/%b/%0d/%0d",
                          a, ci, dec, z, co, sl, lat, e.z, e.co, e.sl, e.lat);
      end
      n_cmp++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_idle got=%b exp=1", bus.ready_o); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.valid_i = 1'b0;
    bus.a_i     = '0;
    bus.ci_i    = 1'b0;
    bus.dec_i   = 1'b0;
    bus.ready_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_inc();
    test_dec();
    test_passthru();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
